// File: rtl/i3c_bus_rx_word_pkg.sv
// Shared types and helpers for the SDR bus word receiver.
package i3c_bus_rx_word_pkg;

  typedef enum logic {
    RX_MODE_WORD = 1'b0,
    RX_MODE_TBIT = 1'b1
  } i3c_rx_mode_e;

  typedef enum logic [1:0] {
    RxIdle = 2'd0,
    RxRecv = 2'd1,
    RxDone = 2'd2
  } i3c_rx_state_e;

  // The T-bit makes the total number of ones odd; returns 1 on a mismatch.
  function automatic logic odd_parity_err(input logic [31:0] data, input logic tbit);
    return ~(^data ^ tbit);
  endfunction

endpackage

// File: rtl/i3c_bus_rx_word_if.sv
// Bus-side strobes and FSM request/result signals of the word receiver.
interface i3c_bus_rx_word_if #(
  parameter int unsigned DataWidth = 8
);
  logic                 sda_i;
  logic                 scl_posedge_i;
  logic                 bus_start_det_i;
  logic                 bus_stop_det_i;
  logic                 rx_req_bit_i;
  logic                 rx_req_word_i;
  logic                 rx_mode_i;
  logic                 rx_idle_o;
  logic                 rx_done_o;
  logic [DataWidth-1:0] rx_data_o;
  logic                 rx_tbit_o;
  logic                 rx_parity_err_o;
  logic                 rx_abort_o;

  modport master (
    output sda_i, scl_posedge_i, bus_start_det_i, bus_stop_det_i,
    output rx_req_bit_i, rx_req_word_i, rx_mode_i,
    input  rx_idle_o, rx_done_o, rx_data_o, rx_tbit_o, rx_parity_err_o, rx_abort_o
  );

  modport slave (
    input  sda_i, scl_posedge_i, bus_start_det_i, bus_stop_det_i,
    input  rx_req_bit_i, rx_req_word_i, rx_mode_i,
    output rx_idle_o, rx_done_o, rx_data_o, rx_tbit_o, rx_parity_err_o, rx_abort_o
  );
endinterface

// File: rtl/i3c_bus_rx_word.sv
// SDR receiver: shifts in one bit or one MSB-first word (optionally plus T-bit)
// on SCL rising-edge strobes and reports done / parity error / abort pulses.
module i3c_bus_rx_word
  import i3c_bus_rx_word_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned CntWidth  = $clog2(DataWidth + 2)
) (
  input logic              clk_i,
  input logic              rst_i,
  i3c_bus_rx_word_if.slave bus
);

  i3c_rx_state_e        state_q, state_d;
  i3c_rx_mode_e         mode_q, mode_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [CntWidth-1:0]  target_q, target_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 tbit_q, tbit_d;
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;
  logic                 abort_q, abort_d;

  logic                 bus_evt_s;
  logic                 req_s;
  logic                 last_s;
  logic [DataWidth-1:0] shift_in_s;

  assign bus_evt_s  = bus.bus_start_det_i | bus.bus_stop_det_i;
  assign req_s      = bus.rx_req_bit_i | bus.rx_req_word_i;
  assign last_s     = ((cnt_q + CntWidth'(1)) == target_q);
  assign shift_in_s = (shift_q << 1'b1) | DataWidth'(bus.sda_i);

  // Next-state, datapath and pulse generation.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    shift_d  = shift_q;
    data_d   = data_q;
    tbit_d   = tbit_q;
    done_d   = 1'b0;
    perr_d   = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      RxIdle: begin
        // A bus condition in the request cycle rejects the request.
        if (req_s && !bus_evt_s) begin
          state_d = RxRecv;
          cnt_d   = '0;
          shift_d = '0;
          if (bus.rx_req_word_i) begin
            mode_d   = i3c_rx_mode_e'(bus.rx_mode_i);
            target_d = bus.rx_mode_i ? CntWidth'(DataWidth + 1) : CntWidth'(DataWidth);
          end else begin
            mode_d   = RX_MODE_WORD;
            target_d = CntWidth'(1);
          end
        end else begin
          state_d = RxIdle;
        end
      end
      RxRecv: begin
        if (bus_evt_s) begin
          state_d = RxIdle;
          abort_d = 1'b1;
        end else if (bus.scl_posedge_i) begin
          if (last_s) begin
            state_d = RxDone;
            done_d  = 1'b1;
            cnt_d   = target_q;
            // In T-bit mode the final sample is the T-bit, the word is already complete.
            if (mode_q == RX_MODE_TBIT) begin
              data_d = shift_q;
              tbit_d = bus.sda_i;
              perr_d = odd_parity_err(32'(shift_q), bus.sda_i);
            end else begin
              data_d = shift_in_s;
              tbit_d = 1'b0;
            end
          end else begin
            cnt_d   = cnt_q + CntWidth'(1);
            shift_d = shift_in_s;
          end
        end else begin
          state_d = RxRecv;
        end
      end
      RxDone: begin
        state_d = RxIdle;
      end
      default: begin
        state_d = RxIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= RxIdle;
      mode_q   <= RX_MODE_WORD;
      cnt_q    <= '0;
      target_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      tbit_q   <= 1'b0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      tbit_q   <= tbit_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
      abort_q  <= abort_d;
    end
  end

  assign bus.rx_idle_o       = (state_q == RxIdle);
  assign bus.rx_done_o       = done_q;
  assign bus.rx_data_o       = data_q;
  assign bus.rx_tbit_o       = tbit_q;
  assign bus.rx_parity_err_o = perr_q;
  assign bus.rx_abort_o      = abort_q;

endmodule

// File: tb/tb_i3c_bus_rx_word.sv
// Randomised scoreboard bench for i3c_bus_rx_word (8-bit and 16-bit instances).
module tb_i3c_bus_rx_word;

  typedef struct {
    bit          abort;
    logic [31:0] data;
    bit          tbit;
    bit          perr;
    int          cyc;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic sda_v[2], scl_v[2], start_v[2], stop_v[2], rb_v[2], rw_v[2], mode_v[2];

  i3c_bus_rx_word_if #(.DataWidth(8))  bus8 ();
  i3c_bus_rx_word_if #(.DataWidth(16)) bus16 ();

  assign bus8.sda_i            = sda_v[0];
  assign bus8.scl_posedge_i    = scl_v[0];
  assign bus8.bus_start_det_i  = start_v[0];
  assign bus8.bus_stop_det_i   = stop_v[0];
  assign bus8.rx_req_bit_i     = rb_v[0];
  assign bus8.rx_req_word_i    = rw_v[0];
  assign bus8.rx_mode_i        = mode_v[0];
  assign bus16.sda_i           = sda_v[1];
  assign bus16.scl_posedge_i   = scl_v[1];
  assign bus16.bus_start_det_i = start_v[1];
  assign bus16.bus_stop_det_i  = stop_v[1];
  assign bus16.rx_req_bit_i    = rb_v[1];
  assign bus16.rx_req_word_i   = rw_v[1];
  assign bus16.rx_mode_i       = mode_v[1];

  i3c_bus_rx_word #(.DataWidth(8))  u_dut8  (.clk_i(clk_i), .rst_i(rst_i), .bus(bus8));
  i3c_bus_rx_word #(.DataWidth(16)) u_dut16 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus16));

  exp_t        q8[$];
  exp_t        q16[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_data[2];
  bit          last_tbit[2];

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void push(int b, exp_t e);
    if (b == 0) q8.push_back(e);
    else q16.push_back(e);
  endfunction

  function automatic void mon(int b, logic done, logic abort, logic [31:0] data,
                              logic tbit, logic perr);
    exp_t e;
    int   sz;
    sz = (b == 0) ? q8.size() : q16.size();
    if (done || abort) begin
      if (sz == 0) begin
        chk($sformatf("unexpected_output_bus%0d", b), 32'd1, 32'd0);
      end else begin
        if (b == 0) e = q8.pop_front();
        else e = q16.pop_front();
        chk("abort_flag", 32'(abort), 32'(e.abort));
        chk("done_flag", 32'(done), 32'(!e.abort));
        chk("rx_data", data, e.data);
        chk("rx_tbit", 32'(tbit), 32'(e.tbit));
        chk("parity_err", 32'(perr), 32'(e.perr));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (perr) begin
      chk("stray_parity_err", 32'(perr), 32'd0);
    end
  endfunction

  // Monitor: consumes scoreboard entries whenever a DUT reports a result.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      mon(0, bus8.rx_done_o, bus8.rx_abort_o, 32'(bus8.rx_data_o),
          bus8.rx_tbit_o, bus8.rx_parity_err_o);
      mon(1, bus16.rx_done_o, bus16.rx_abort_o, 32'(bus16.rx_data_o),
          bus16.rx_tbit_o, bus16.rx_parity_err_o);
    end
  end

  task automatic clr(int b);
    scl_v[b] = 1'b0; start_v[b] = 1'b0; stop_v[b] = 1'b0;
    rb_v[b]  = 1'b0; rw_v[b]    = 1'b0;
  endtask

  task automatic wait_idle(int b);
    int n;
    n = 0;
    while (!((b == 0) ? bus8.rx_idle_o : bus16.rx_idle_o) && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 40) chk("idle_wait_timeout", 32'd0, 32'd1);
  endtask

  // One request; abort_at = -1 none, -2 random position, else sample index of abort.
  task automatic txn(int b, bit is_word, bit mode, bit use_pat, logic [32:0] pat,
                     int abort_at_in, bit edge_on_accept, bit both_req,
                     bit extra_req, bit req_in_done, int max_gap);
    int          dw, n, gap, abort_at;
    bit          v;
    bit          bits[$];
    logic [31:0] word;
    bit          tb_bit;
    exp_t        e;
    dw = (b == 0) ? 8 : 16;
    n  = is_word ? (mode ? dw + 1 : dw) : 1;
    abort_at = (abort_at_in == -2) ? int'($urandom_range(n - 1, 0)) : abort_at_in;
    wait_idle(b);
    rw_v[b]   = is_word;
    rb_v[b]   = !is_word || both_req;
    mode_v[b] = is_word ? mode : 1'($urandom);
    scl_v[b]  = edge_on_accept;
    sda_v[b]  = 1'($urandom);
    @(negedge clk_i);
    clr(b);
    for (int i = 0; i < n; i++) begin
      gap = int'($urandom_range(max_gap, 0));
      for (int g = 0; g < gap; g++) begin
        sda_v[b] = 1'($urandom);
        if (extra_req && g == 0) begin
          rw_v[b] = 1'b1;
          rb_v[b] = 1'($urandom);
        end
        @(negedge clk_i);
        clr(b);
      end
      v = use_pat ? pat[n - 1 - i] : 1'($urandom);
      sda_v[b] = v;
      scl_v[b] = 1'b1;
      if (i == abort_at) begin
        if ($urandom_range(1, 0) == 0) start_v[b] = 1'b1;
        else stop_v[b] = 1'b1;
        e.abort = 1'b1; e.data = last_data[b]; e.tbit = last_tbit[b];
        e.perr = 1'b0; e.cyc = cyc + 1;
        push(b, e);
        @(negedge clk_i);
        clr(b);
        return;
      end
      bits.push_back(v);
      if (i == n - 1) begin
        if (is_word) begin
          word = 32'd0;
          for (int k = 0; k < dw; k++) word = word * 32'd2 + 32'(bits[k]);
          tb_bit = mode ? bits[dw] : 1'b0;
          e.perr = mode && ((($countones(word) + int'(tb_bit)) % 2) == 0);
        end else begin
          word   = 32'(bits[0]);
          tb_bit = 1'b0;
          e.perr = 1'b0;
        end
        e.abort = 1'b0; e.data = word; e.tbit = tb_bit; e.cyc = cyc + 1;
        push(b, e);
        last_data[b] = word;
        last_tbit[b] = tb_bit;
      end
      @(negedge clk_i);
      clr(b);
    end
    if (req_in_done) begin
      rw_v[b] = 1'b1;
      @(negedge clk_i);
      clr(b);
      chk("req_in_done_ignored", 32'((b == 0) ? bus8.rx_idle_o : bus16.rx_idle_o), 32'd1);
    end
  endtask

  task automatic chk_reset8();
    chk("rst_idle", 32'(bus8.rx_idle_o), 32'd1);
    chk("rst_done", 32'(bus8.rx_done_o), 32'd0);
    chk("rst_data", 32'(bus8.rx_data_o), 32'd0);
    chk("rst_tbit", 32'(bus8.rx_tbit_o), 32'd0);
    chk("rst_perr", 32'(bus8.rx_parity_err_o), 32'd0);
    chk("rst_abort", 32'(bus8.rx_abort_o), 32'd0);
    chk("rst_data16", 32'(bus16.rx_data_o), 32'd0);
  endtask

  initial begin
    exp_t e;
    rst_i = 1'b1;
    for (int b = 0; b < 2; b++) begin
      clr(b);
      sda_v[b] = 1'b0; mode_v[b] = 1'b0;
      last_data[b] = 32'd0; last_tbit[b] = 1'b0;
    end
    repeat (2) @(negedge clk_i);
    chk_reset8();
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed cases on the 8-bit instance.
    txn(0, 1'b1, 1'b0, 1'b1, 33'h0A5, -1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    txn(0, 1'b1, 1'b0, 1'b0, 33'h0,    4, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    txn(0, 1'b1, 1'b1, 1'b1, 33'h079, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    txn(0, 1'b1, 1'b1, 1'b1, 33'h078, -1, 1'b0, 1'b1, 1'b0, 1'b1, 2);

    // Bit request with the edge right after acceptance: idle low for exactly two cycles.
    wait_idle(0);
    rb_v[0] = 1'b1; mode_v[0] = 1'b1;
    @(negedge clk_i);
    clr(0);
    chk("bit_idle_low_recv", 32'(bus8.rx_idle_o), 32'd0);
    sda_v[0] = 1'b1; scl_v[0] = 1'b1;
    e.abort = 1'b0; e.data = 32'd1; e.tbit = 1'b0; e.perr = 1'b0; e.cyc = cyc + 1;
    push(0, e);
    last_data[0] = 32'd1; last_tbit[0] = 1'b0;
    @(negedge clk_i);
    clr(0);
    chk("bit_idle_low_done", 32'(bus8.rx_idle_o), 32'd0);
    @(negedge clk_i);
    chk("bit_idle_back", 32'(bus8.rx_idle_o), 32'd1);

    // Bus conditions in IDLE are ignored; one coinciding with a request rejects it.
    stop_v[0] = 1'b1;
    @(negedge clk_i);
    clr(0);
    start_v[0] = 1'b1; rw_v[0] = 1'b1;
    @(negedge clk_i);
    clr(0);
    chk("req_with_start_rejected", 32'(bus8.rx_idle_o), 32'd1);

    // Abort coinciding with the final sample.
    txn(0, 1'b1, 1'b0, 1'b0, 33'h0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // 16-bit instance: 0x8001 with T-bit 1.
    txn(1, 1'b1, 1'b1, 1'b1, {16'h0, 16'h8001, 1'b1}, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // Randomised traffic on both instances.
    for (int t = 0; t < 60; t++) begin
      txn(t % 3 == 2 ? 1 : 0, ($urandom_range(3, 0) != 0), 1'($urandom), 1'b0, 33'h0,
          ($urandom_range(7, 0) == 0) ? -2 : -1, 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 2);
    end

    // Reset in the middle of a word.
    wait_idle(0);
    rw_v[0] = 1'b1; mode_v[0] = 1'b0;
    @(negedge clk_i);
    clr(0);
    for (int i = 0; i < 3; i++) begin
      sda_v[0] = 1'b1; scl_v[0] = 1'b1;
      @(negedge clk_i);
      clr(0);
    end
    rst_i = 1'b1;
    #1;
    chk_reset8();
    @(negedge clk_i);
    rst_i = 1'b0;
    last_data[0] = 32'd0; last_tbit[0] = 1'b0;
    last_data[1] = 32'd0; last_tbit[1] = 1'b0;
    txn(0, 1'b1, 1'b0, 1'b1, 33'h05A, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    repeat (5) @(negedge clk_i);
    chk("scoreboard8_drained", 32'(q8.size()), 32'd0);
    chk("scoreboard16_drained", 32'(q16.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
